// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with hardware clear
// after reset, same-cycle write bypass and a per-register pending-write scoreboard.
`default_nettype none

module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rpend,
  input  logic                iss,
  input  logic [AW-1:0]       isa,
  output logic                ready
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] C_LAST = AW'(NREGS - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] pend_q, pend_d;
  logic [XLEN-1:0]  rf_q [NREGS];

  logic w_run;
  logic w_wr;
  logic w_set;

  assign w_run = (state_q == S_RUN);
  assign w_wr  = w_run && we && (wa != '0);
  assign w_set = w_run && iss && (isa != '0);
  assign ready = w_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Clear first so a same-address issue overrides the retiring write.
        if (w_wr) begin
          pend_d[wa] = 1'b0;
        end
        if (w_set) begin
          pend_d[isa] = 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
    pend_d[0] = 1'b0;
  end

  // Storage carries no reset; the clear sequencer zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      rf_q[cnt_q] <= '0;
    end else if (w_wr) begin
      rf_q[wa] <= wd;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;

    assign w_ra  = ra[i*AW +: AW];
    assign w_hit = (BYPASS != 0) && w_wr && (wa == w_ra);

    always_comb begin
      rd[i*XLEN +: XLEN] = '0;
      if (w_run && (w_ra != '0)) begin
        rd[i*XLEN +: XLEN] = w_hit ? wd : rf_q[w_ra];
      end
    end

    assign rpend[i] = w_run && pend_q[w_ra];
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp (bypass and
// non-bypass instances sharing one stimulus) against an array-based model.
`default_nettype none

module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic                iss;
  logic [AW-1:0]       isa;
  logic [NRD*XLEN-1:0] rd_a, rd_b;
  logic [NRD-1:0]      rpend_a, rpend_b;
  logic                ready_a, ready_b;

  int errors = 0;
  int checks = 0;

  // Reference model
  bit              ready_m;
  int              edges_m;
  logic [XLEN-1:0] mem_m [NREGS];
  bit              pend_m [NREGS];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
    .rpend(rpend_a), .iss(iss), .isa(isa), .ready(ready_a)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
    .rpend(rpend_b), .iss(iss), .isa(isa), .ready(ready_b)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!ready_m || a == '0) return '0;
    if (byp && we && wa == a) return wd;
    return mem_m[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    return ready_m && (a != '0) && pend_m[a];
  endfunction

  task automatic model_reset();
    ready_m = 1'b0;
    edges_m = 0;
    for (int r = 0; r < NREGS; r++) pend_m[r] = 1'b0;
  endtask

  // Advance one rising edge, updating the model from the inputs held across it.
  task automatic tick();
    if (!reset) begin
      if (!ready_m) begin
        edges_m++;
        if (edges_m == NREGS) begin
          ready_m = 1'b1;
          for (int r = 0; r < NREGS; r++) mem_m[r] = '0;
        end
      end else begin
        if (we && wa != '0) begin
          mem_m[wa]  = wd;
          pend_m[wa] = 1'b0;
        end
        if (iss && isa != '0) pend_m[isa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; iss = 1'b0; isa = '0; ra = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    idle_inputs();
    repeat (3) tick();
    ra = {5'd3, 5'd2, 5'd1};
    #1;
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b/%b expected 0", ready_a, ready_b);
    end
    checks++;
    if (rd_a !== '0 || rpend_a !== '0) begin
      errors++; $display("FAIL reset_outputs: rd=%h rpend=%b expected 0", rd_a, rpend_a);
    end
    reset = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      checks++;
      if (ready_a !== 1'b0) begin
        errors++; $display("FAIL clear_ready_early: edge %0d got %b expected 0", k, ready_a);
      end
      tick();
    end
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      errors++; $display("FAIL clear_ready_done: got %b/%b expected 1", ready_a, ready_b);
    end
    for (int r = 1; r < NREGS; r++) begin
      ra = {3{AW'(r)}};
      #1;
      checks++;
      if (rd_a !== '0 || rd_b !== '0 || rpend_a !== '0) begin
        errors++; $display("FAIL cleared_read: addr %0d rd=%h rpend=%b expected 0", r, rd_a, rpend_a);
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd0, 5'd0, 5'd5};
    #1;
    checks++;
    if (rd_a[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_a[31:0]);
    end
    checks++;
    if (rd_b[31:0] !== 32'h0) begin
      errors++; $display("FAIL nobypass_same_cycle: got %h expected 00000000", rd_b[31:0]);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rd_b[31:0] !== 32'hDEADBEEF || rd_a[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_stored: got %h/%h expected deadbeef", rd_a[31:0], rd_b[31:0]);
    end
  endtask

  task automatic test_r0();
    idle_inputs();
    we = 1'b1; wa = '0; wd = 32'h12345678; iss = 1'b1; isa = '0; ra = '0;
    #1;
    checks++;
    if (rd_a !== '0 || rd_b !== '0) begin
      errors++; $display("FAIL r0_bypass: got %h expected 0", rd_a);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_a !== '0 || rd_b !== '0 || rpend_a !== '0 || rpend_b !== '0) begin
      errors++; $display("FAIL r0_after: rd=%h rpend=%b expected 0", rd_a, rpend_a);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    iss = 1'b1; isa = 5'd7; ra = {5'd0, 5'd0, 5'd7};
    #1;
    checks++;
    if (rpend_a[0] !== 1'b0) begin
      errors++; $display("FAIL pend_not_yet: got %b expected 0", rpend_a[0]);
    end
    tick();
    iss = 1'b0;
    #1;
    checks++;
    if (rpend_a[0] !== 1'b1 || rpend_b[0] !== 1'b1) begin
      errors++; $display("FAIL pend_set: got %b/%b expected 1", rpend_a[0], rpend_b[0]);
    end
    iss = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'h11;
    tick();
    iss = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'h22;
    #1;
    checks++;
    if (rpend_a[0] !== 1'b1) begin
      errors++; $display("FAIL pend_set_wins: got %b expected 1", rpend_a[0]);
    end
    tick();
    we = 1'b0;
    #1;
    checks++;
    if (rpend_a[0] !== 1'b0 || rpend_b[0] !== 1'b0) begin
      errors++; $display("FAIL pend_cleared: got %b/%b expected 0", rpend_a[0], rpend_b[0]);
    end
  endtask

  task automatic test_multiport();
    idle_inputs();
    we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
    tick();
    we = 1'b0; ra = {3{5'd9}};
    #1;
    for (int p = 0; p < NRD; p++) begin
      checks++;
      if (rd_a[p*XLEN +: XLEN] !== 32'hA5A5A5A5 || rd_b[p*XLEN +: XLEN] !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL multiport port%0d: got %h/%h expected a5a5a5a5",
                 p, rd_a[p*XLEN +: XLEN], rd_b[p*XLEN +: XLEN]);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 300; c++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, 7));
      wd  = $urandom;
      iss = 1'($urandom_range(0, 1));
      isa = AW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) ra[p*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = ra[p*AW +: AW];
        checks++;
        if (rd_a[p*XLEN +: XLEN] !== exp_rd(a, 1'b1)) begin
          errors++; $display("FAIL rand_rd_byp c%0d p%0d a%0d: got %h expected %h",
                             c, p, a, rd_a[p*XLEN +: XLEN], exp_rd(a, 1'b1));
        end
        checks++;
        if (rd_b[p*XLEN +: XLEN] !== exp_rd(a, 1'b0)) begin
          errors++; $display("FAIL rand_rd_nobyp c%0d p%0d a%0d: got %h expected %h",
                             c, p, a, rd_b[p*XLEN +: XLEN], exp_rd(a, 1'b0));
        end
        checks++;
        if (rpend_a[p] !== exp_pend(a) || rpend_b[p] !== exp_pend(a)) begin
          errors++; $display("FAIL rand_pend c%0d p%0d a%0d: got %b/%b expected %b",
                             c, p, a, rpend_a[p], rpend_b[p], exp_pend(a));
        end
      end
      tick();
    end
  endtask

  task automatic test_midclear();
    idle_inputs();
    we = 1'b1; wa = 5'd3; wd = 32'h0000FFFF;
    tick();
    idle_inputs();
    ra = {3{5'd3}};
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h0000FFFF) begin
      errors++; $display("FAIL pre_reset_write: got %h expected 0000ffff", rd_a[31:0]);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ready_a !== 1'b0 || rd_a !== '0) begin
      errors++; $display("FAIL async_reset: ready=%b rd=%h expected 0", ready_a, rd_a);
    end
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      we = 1'b1; wa = AW'($urandom_range(1, 31)); wd = $urandom;
      iss = 1'b1; isa = AW'($urandom_range(1, 31));
      tick();
    end
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      we = 1'b1; wa = 5'd3; wd = $urandom; iss = 1'b1; isa = 5'd3;
      #1;
      checks++;
      if (ready_a !== 1'b0 || rpend_a !== '0 || rd_a !== '0) begin
        errors++; $display("FAIL reclear k%0d: ready=%b rpend=%b rd=%h expected 0",
                           k, ready_a, rpend_a, rd_a);
      end
      tick();
    end
    idle_inputs();
    ra = {3{5'd3}};
    #1;
    checks++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      errors++; $display("FAIL reclear_ready: got %b/%b expected 1", ready_a, ready_b);
    end
    checks++;
    if (rd_a !== '0 || rd_b !== '0 || rpend_a !== '0) begin
      errors++; $display("FAIL reclear_reg3: rd=%h rpend=%b expected 0", rd_a, rpend_a);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_multiport();
    test_random();
    test_midclear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file for the pipelined RV32I datapath. It is the successor to the 2-read/1-write register file and adds:
- configurable width, depth and read-port count
- rising-edge writes with same-cycle write-to-read bypass, replacing dual-edge writes
- a hardware clear sequencer run after reset
- a per-register pending-write scoreboard used by the hazard unit

It sits in the decode stage: reads feed ID/EX, writes come from writeback.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of registers; power of two, at least 2
NRD, 2, number of read ports, 1..4
AW, $clog2(NREGS), address width (derived; do not override)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
we  in  1  write enable (writeback stage)
wa  in  AW  write address
wd  in  XLEN  write data
ra  in  NRD*AW  read addresses; port i = ra[i*AW +: AW]
rd  out  NRD*XLEN  read data; port i = rd[i*XLEN +: XLEN]
rpend  out  NRD  port i register has an outstanding write (scoreboard bit)
iss  in  1  issue: mark register isa as pending
isa  in  AW  destination address of issuing instruction
ready  out  1  high once the clear sequence has completed

Behaviour:
- Storage array has no reset. Only the FSM, the clear counter and the scoreboard use async reset.
- FSM states: CLEAR, RUN.
  - reset asserted (async) -> state=CLEAR, cnt=0, ready=0, all scoreboard bits=0.
  - CLEAR: each rising edge writes 0 to rf[cnt], then cnt++.
  - When cnt==NREGS-1 is written, next state=RUN and ready=1. The clear takes exactly NREGS cycles after reset deasserts.
  - RUN stays in RUN until the next reset.
- Reset asserted mid-CLEAR restarts the sequence from cnt=0. Reset asserted in RUN reclears the whole array.
- In CLEAR, the we and iss inputs are ignored, all rd = 0 and all rpend = 0.
- Register 0 is hardwired:
  - reads of address 0 return 0 regardless of the stored value or bypass
  - writes to address 0 are discarded
  - iss to address 0 never sets a pending bit
- Write: in RUN with we=1 and wa!=0, rf[wa] <= wd on the rising edge.
- Read: combinational, zero latency. rd[i] = rf[ra[i]], with the following exceptions:
  - BYPASS=1, we=1, wa==ra[i], wa!=0, RUN -> rd[i] = wd in the same cycle.
  - Multiple ports reading the same address all receive identical data.
- Scoreboard: pend[NREGS], with pend[0] always 0.
  - iss=1 (RUN, isa!=0) sets pend[isa] on the edge.
  - we=1 (RUN, wa!=0) clears pend[wa] on the edge.
  - iss and we to the same address in the same cycle: the set wins, so pend=1 (new producer issued after the old one retired).
  - iss and we to different addresses: both take effect.
- rpend[i] = pend[ra[i]] from registered state. It is not bypassed: a write in the current cycle clears the bit only from the next cycle.
- Out-of-range addresses cannot occur, since NREGS is a power of two.
- Reset values: ready=0, rpend=0, rd=0 (while in CLEAR).

Test Plan:
- Reset 3 cycles then release with NREGS=32 -> ready stays 0 for exactly 32 edges then goes 1; all ra=1..31 read 0x00000000; rpend=0.
- RUN, we=1 wa=5 wd=0xDEADBEEF, ra port0=5 in the same cycle -> rd0=0xDEADBEEF combinationally (BYPASS=1). With BYPASS=0, rd0 = old value (0) until after the edge, then 0xDEADBEEF.
- we=1 wa=0 wd=0x12345678, then read ra=0 on all ports -> 0 every cycle; iss isa=0 -> rpend stays 0.
- iss isa=7 -> next cycle rpend0=1 for ra0=7; then iss isa=7 and we wa=7 together -> pend stays 1; then we wa=7 alone -> rpend0=0 from the following cycle.
- NRD=3, all ports read ra=9 after writing 0xA5A5A5A5 -> rd0=rd1=rd2=0xA5A5A5A5.
- Reset asserted at clear cycle 10, released -> full 32-cycle clear repeats. Register 3 was written 0xFFFF before the reset in RUN and reads 0 after ready=1. we pulses during CLEAR have no effect.
